udp_receive_handler: RTL and testbench
======================================

# udp_receive_handler

Receive-side counterpart of the virtual port's UDP transmit path. Accepts a decoded UDP packet (header fields plus payload bytes) from the UDP receiver and serializes it into the 9-bit virtual-port byte stream. Bit 8 marks the first byte of each packet. The stream carries source MAC, source IPv4, UDP ports, UDP data size, then the payload. Oversized packets are drained and discarded without emitting anything.

## Interface
Parameters:
- MAXIMUM_UDP_DATA_SIZE, 1472, largest payload forwarded; larger packets are dropped.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- header_valid  input  1  header fields below are valid.
- header_ready  output  1  block accepts a header; a header transfers when header_valid && header_ready.
- mac_source  input  48  sender MAC address.
- ipv4_source  input  32  sender IPv4 address.
- udp_source  input  16  UDP source port.
- udp_destination  input  16  UDP destination port.
- udp_data_size  input  16  payload length in bytes.
- udp_data  input  8  payload byte.
- udp_data_valid  input  1  udp_data is valid.
- udp_data_ready  output  1  payload byte consumed when udp_data_valid && udp_data_ready.
- data  output  9  stream byte; bit 8 = start of packet.
- data_valid  output  1  data is valid.
- data_ready  input  1  downstream accepts; a byte transfers when data_valid && data_ready.
- data_last  output  1  current data is the final byte of the packet.
- oversize_drop  output  1  one-cycle pulse when an oversized packet finishes draining.
- ready  output  1  idle with the output register empty.

## Operation
- Stream format is 16 header bytes, then udp_data_size payload bytes. All header fields are sent MSB first, in this order:
  - mac_source: 6 bytes
  - ipv4_source: 4 bytes
  - udp_source: 2 bytes
  - udp_destination: 2 bytes
  - udp_data_size: 2 bytes
- data[8] = 1 only on header byte 0; 0 on every other byte.
- States:
  - S_IDLE
    - header_ready = !data_valid.
    - On a header transfer, latch all fields into a 128-bit header shift register and load the 16-bit remaining-count from udp_data_size.
    - If udp_data_size > MAXIMUM_UDP_DATA_SIZE, go to S_DRAIN; otherwise go to S_SEND_HEADER.
  - S_SEND_HEADER
    - When !data_valid || data_ready, load the next header byte into the output register and advance the 4-bit header counter.
    - After byte 15 is loaded, go to S_SEND_PAYLOAD if count != 0, else to S_IDLE. In the count = 0 case, data_last = 1 on byte 15.
  - S_SEND_PAYLOAD
    - udp_data_ready = !data_valid || data_ready.
    - On a payload transfer: data <= {1'b0, udp_data}, data_valid <= 1, count decrements.
    - When the byte with count == 1 is loaded, set data_last and go to S_IDLE.
  - S_DRAIN
    - udp_data_ready = 1; each payload transfer decrements count.
    - On the transfer with count == 1: pulse oversize_drop next cycle and go to S_IDLE.
    - data_valid stays 0 throughout.
- data_valid drops after a transfer only if no new byte loads in the same cycle.
- data_last is qualified by data_valid.
- Size comparison is unsigned, full 16-bit. The count never wraps; it is only decremented when nonzero.

## Timing
- Reset (synchronous, reset_n = 0 at an edge) has these effects, including mid-packet; any partial packet is abandoned:
  - state = S_IDLE
  - data = 0, data_valid = 0, data_last = 0, oversize_drop = 0
  - counters = 0, header register = 0
  - header_ready = 1, ready = 1
- Header accepted at edge k → byte 0 presented from k+1 with data_valid = 1.
- With data_ready held at 1, one byte is emitted per cycle: a packet of N bytes occupies cycles k+1 … k+16+N, provided payload is available.
- udp_data_ready is combinational from state and output-register occupancy. A payload byte accepted at edge j appears on data at j+1.
- A stalled output (data_valid && !data_ready) holds data, data_valid and data_last stable, and forces udp_data_ready = 0 in S_SEND_PAYLOAD.
- Next header is accepted no earlier than the cycle after the last byte transfers; there is no packet overlap.
- oversize_drop is high exactly one cycle, on the cycle after the final drained byte.
- header_valid outside S_IDLE is ignored (header_ready = 0).

## Test plan
- Basic packet, data_ready = 1:
  - Stimulus: mac 0x0A1B2C3D4E5F, ip 0xC0A80164, src 0x1F90, dst 0x0035, size 4, payload 11 22 33 44.
  - Required response: 20 consecutive bytes 0x10A, 0x01B, …, 0x05F, 0x0C0, …, 0x064, 0x01F, 0x090, 0x000, 0x035, 0x000, 0x004, 0x011, 0x022, 0x033, 0x044; data_last only on 0x044.
- Zero length, size 0 → exactly 16 bytes; data_last on the final 0x000; udp_data_ready never asserted.
- Backpressure: same packet with data_ready = 0 on alternate cycles → every byte held until transferred, order unchanged, no duplicates; udp_data_ready = 0 during stalls.
- Oversize, size 1473 → data_valid stays 0; 1473 payload beats accepted; oversize_drop pulses once; ready = 1 afterwards. Size 1472 → forwarded normally.
- Reset mid-payload: reset_n = 0 for 1 cycle after payload byte 2 → all outputs at reset values next cycle. A following size-4 packet streams correctly.
- Back-to-back: header_valid held high with two headers → second header_ready only after first packet's data_last transfers; second packet's byte 0 has data[8] = 1.

Source files
------------

// File: rtl/udp_receive_handler.sv
// Serializes a decoded UDP packet (header fields plus payload) into the 9-bit
// virtual-port byte stream; bit 8 flags the first byte. Oversized packets are drained silently.
module udp_receive_handler #(
    parameter int unsigned MAXIMUM_UDP_DATA_SIZE = 1472
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        header_valid,
    output logic        header_ready,
    input  logic [47:0] mac_source,
    input  logic [31:0] ipv4_source,
    input  logic [15:0] udp_source,
    input  logic [15:0] udp_destination,
    input  logic [15:0] udp_data_size,
    input  logic [7:0]  udp_data,
    input  logic        udp_data_valid,
    output logic        udp_data_ready,
    output logic [8:0]  data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        data_last,
    output logic        oversize_drop,
    output logic        ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND_HEADER,
        S_SEND_PAYLOAD,
        S_DRAIN
    } state_t;

    localparam logic [15:0] MAX_SIZE = 16'(MAXIMUM_UDP_DATA_SIZE);

    state_t        state_reg;
    state_t        state_next;
    logic [127:0]  header_reg;
    logic [15:0]   count_reg;
    logic [3:0]    hdr_cnt_reg;

    logic          load_en;
    logic          header_xfer;
    logic          payload_xfer;
    logic          oversize;

    // The output register can take a new byte when empty or being emptied this cycle.
    assign load_en      = !data_valid || data_ready;
    assign oversize     = udp_data_size > MAX_SIZE;
    assign header_xfer  = header_valid && header_ready;
    assign payload_xfer = udp_data_valid && udp_data_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (header_xfer) begin
                    state_next = oversize ? S_DRAIN : S_SEND_HEADER;
                end
            end
            S_SEND_HEADER: begin
                if (load_en && hdr_cnt_reg == 4'd15) begin
                    state_next = (count_reg != 16'd0) ? S_SEND_PAYLOAD : S_IDLE;
                end
            end
            S_SEND_PAYLOAD: begin
                if (payload_xfer && count_reg == 16'd1) begin
                    state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (payload_xfer && count_reg == 16'd1) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        header_ready   = 1'b0;
        udp_data_ready = 1'b0;
        ready          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                header_ready = !data_valid;
                ready        = !data_valid;
            end
            S_SEND_PAYLOAD: udp_data_ready = load_en;
            S_DRAIN:        udp_data_ready = 1'b1;
            default:        ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data          <= '0;
            data_valid    <= 1'b0;
            data_last     <= 1'b0;
            oversize_drop <= 1'b0;
            header_reg    <= '0;
            count_reg     <= '0;
            hdr_cnt_reg   <= '0;
        end else begin
            oversize_drop <= 1'b0;
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
                data_last  <= 1'b0;
            end
            case (state_reg)
                S_IDLE: begin
                    if (header_xfer) begin
                        // Byte 0 goes straight to the output; the register keeps bytes 1..15 MSB-aligned.
                        header_reg  <= {mac_source[39:0], ipv4_source, udp_source,
                                        udp_destination, udp_data_size, 8'h00};
                        count_reg   <= udp_data_size;
                        hdr_cnt_reg <= 4'd0;
                        if (!oversize) begin
                            data        <= {1'b1, mac_source[47:40]};
                            data_valid  <= 1'b1;
                            data_last   <= 1'b0;
                            hdr_cnt_reg <= 4'd1;
                        end
                    end
                end
                S_SEND_HEADER: begin
                    if (load_en) begin
                        data        <= {1'b0, header_reg[127:120]};
                        data_valid  <= 1'b1;
                        data_last   <= (hdr_cnt_reg == 4'd15) && (count_reg == 16'd0);
                        header_reg  <= {header_reg[119:0], 8'h00};
                        hdr_cnt_reg <= hdr_cnt_reg + 4'd1;
                    end
                end
                S_SEND_PAYLOAD: begin
                    if (payload_xfer) begin
                        data       <= {1'b0, udp_data};
                        data_valid <= 1'b1;
                        data_last  <= (count_reg == 16'd1);
                        if (count_reg != 16'd0) begin
                            count_reg <= count_reg - 16'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (payload_xfer && count_reg != 16'd0) begin
                        count_reg <= count_reg - 16'd1;
                        if (count_reg == 16'd1) begin
                            oversize_drop <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_receive_handler.sv
// Directed bench for udp_receive_handler: drives headers and payload, records every
// stream transfer and checks content, framing, timing, backpressure, drain and reset.
module tb_udp_receive_handler;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        header_valid = 1'b0;
    logic        header_ready;
    logic [47:0] mac_source = '0;
    logic [31:0] ipv4_source = '0;
    logic [15:0] udp_source = '0;
    logic [15:0] udp_destination = '0;
    logic [15:0] udp_data_size = '0;
    logic [7:0]  udp_data;
    logic        udp_data_valid;
    logic        udp_data_ready;
    logic [8:0]  data;
    logic        data_valid;
    logic        data_ready = 1'b1;
    logic        data_last;
    logic        oversize_drop;
    logic        ready;

    int checks = 0;
    int failures = 0;

    // Payload source: pay_idx is owned by the feeder, the main sequence only moves pay_end.
    logic [7:0] pay_mem [0:4095];
    int         pay_idx = 0;
    int         pay_end = 0;
    bit         bp_mode = 1'b0;

    logic [9:0] out_q [$];
    int         out_cyc [$];
    int         hdr_cyc [$];
    int         cyc = 0;
    int         drop_cnt = 0;
    int         dv_cnt = 0;
    int         udr_cnt = 0;
    int         stall_cnt = 0;
    int         stall_viol = 0;
    int         hold_viol = 0;
    bit         prev_stall = 1'b0;
    logic [10:0] prev_word = '0;
    bit         pf;

    assign udp_data       = pay_mem[pay_idx[11:0]];
    assign udp_data_valid = (pay_idx < pay_end);

    udp_receive_handler #(.MAXIMUM_UDP_DATA_SIZE(1472)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .header_valid    (header_valid),
        .header_ready    (header_ready),
        .mac_source      (mac_source),
        .ipv4_source     (ipv4_source),
        .udp_source      (udp_source),
        .udp_destination (udp_destination),
        .udp_data_size   (udp_data_size),
        .udp_data        (udp_data),
        .udp_data_valid  (udp_data_valid),
        .udp_data_ready  (udp_data_ready),
        .data            (data),
        .data_valid      (data_valid),
        .data_ready      (data_ready),
        .data_last       (data_last),
        .oversize_drop   (oversize_drop),
        .ready           (ready)
    );

    always #5 clock = ~clock;

    // Monitor and payload feeder: observe at negedge, update sources just after posedge.
    always begin
        @(negedge clock);
        cyc++;
        pf = udp_data_valid && udp_data_ready;
        if (data_valid && data_ready) begin
            out_q.push_back({data_last, data});
            out_cyc.push_back(cyc);
        end
        if (header_valid && header_ready) hdr_cyc.push_back(cyc);
        if (oversize_drop) drop_cnt++;
        if (data_valid) dv_cnt++;
        if (udp_data_ready) udr_cnt++;
        if (data_valid && !data_ready) stall_cnt++;
        if (data_valid && !data_ready && udp_data_ready) stall_viol++;
        if (prev_stall && ({data_valid, data_last, data} !== prev_word)) hold_viol++;
        prev_stall = data_valid && !data_ready;
        prev_word  = {data_valid, data_last, data};
        @(posedge clock);
        #1;
        if (pf) pay_idx++;
        data_ready = bp_mode ? ~data_ready : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] mk_hdr(input logic [47:0] m, input logic [31:0] ip,
                                           input logic [15:0] s, input logic [15:0] d,
                                           input logic [15:0] z);
        return {m, ip, s, d, z};
    endfunction

    task automatic setup_payload(input int n, input int avail, input int seed, input int step,
                                 output int base);
        base = pay_idx;
        for (int i = 0; i < n; i++) pay_mem[12'(base + i)] = 8'(seed + i * step);
        pay_end = base + avail;
    endtask

    task automatic wait_hdr(input string tag, input int n, input int budget);
        int t = 0;
        while (hdr_cyc.size() < n && t < budget) begin
            @(negedge clock);
            t++;
        end
        chk({tag, "_hdr_accept"}, 32'(hdr_cyc.size() >= n), 32'd1);
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int t = 0;
        while (out_q.size() < n && t < budget) begin
            @(negedge clock);
            t++;
        end
        chk({tag, "_out_done"}, 32'(out_q.size() >= n), 32'd1);
    endtask

    task automatic drive_fields(input logic [127:0] h);
        mac_source      = h[127:80];
        ipv4_source     = h[79:48];
        udp_source      = h[47:32];
        udp_destination = h[31:16];
        udp_data_size   = h[15:0];
    endtask

    task automatic send_header(input string tag, input logic [127:0] h);
        int h0;
        h0 = hdr_cyc.size();
        @(posedge clock);
        #2;
        drive_fields(h);
        header_valid = 1'b1;
        wait_hdr(tag, h0 + 1, 200);
        @(posedge clock);
        #2;
        header_valid = 1'b0;
    endtask

    // Compare recorded stream words against the header and payload the bench built.
    task automatic check_pkt(input string tag, input logic [127:0] h, input int n,
                             input int pbase, input int qbase);
        int errs = 0;
        logic [7:0] b;
        logic [9:0] e;
        logic [9:0] e_first;
        logic [9:0] e_last;
        e_first = '0;
        e_last  = '0;
        for (int i = 0; i < 16 + n; i++) begin
            b = (i < 16) ? h[127 - 8 * i -: 8] : pay_mem[12'(pbase + i - 16)];
            e = {(i == 15 + n), (i == 0), b};
            if (i == 0) e_first = e;
            if (i == 15 + n) e_last = e;
            if (qbase + i < out_q.size()) begin
                if (out_q[qbase + i] !== e) errs++;
            end else begin
                errs++;
            end
        end
        chk({tag, "_byte_errors"}, 32'(errs), 32'd0);
        chk({tag, "_first_word"}, 32'(out_q[qbase]), 32'(e_first));
        chk({tag, "_last_word"}, 32'(out_q[qbase + 15 + n]), 32'(e_last));
    endtask

    initial begin : main
        logic [127:0] h1;
        logic [127:0] h2;
        logic [9:0]   exp1 [0:19];
        int q0;
        int h0;
        int p0;
        int pb;
        int c;
        int d0;
        int dv0;
        int u0;
        int s0;
        int sv0;
        int hv0;

        exp1 = '{10'h10A, 10'h01B, 10'h02C, 10'h03D, 10'h04E, 10'h05F, 10'h0C0, 10'h0A8,
                 10'h001, 10'h064, 10'h01F, 10'h090, 10'h000, 10'h035, 10'h000, 10'h004,
                 10'h011, 10'h022, 10'h033, 10'h244};

        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        @(negedge clock);
        chk("reset_data", 32'(data), 32'h0);
        chk("reset_data_valid", 32'(data_valid), 32'h0);
        chk("reset_data_last", 32'(data_last), 32'h0);
        chk("reset_oversize_drop", 32'(oversize_drop), 32'h0);
        chk("reset_header_ready", 32'(header_ready), 32'h1);
        chk("reset_ready", 32'(ready), 32'h1);
        chk("reset_udp_data_ready", 32'(udp_data_ready), 32'h0);

        // Basic packet with hand-computed stream and cycle-exact placement.
        h1 = mk_hdr(48'h0A1B2C3D4E5F, 32'hC0A80164, 16'h1F90, 16'h0035, 16'd4);
        q0 = out_q.size();
        h0 = hdr_cyc.size();
        @(posedge clock);
        #2;
        setup_payload(4, 4, 8'h11, 8'h11, pb);
        send_header("basic", h1);
        wait_out("basic", q0 + 20, 100);
        repeat (4) @(negedge clock);
        chk("basic_count", 32'(out_q.size() - q0), 32'd20);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("basic_byte%0d", i), 32'(out_q[q0 + i]), 32'(exp1[i]));
        end
        c = hdr_cyc[h0];
        chk("basic_first_latency", 32'(out_cyc[q0] - c), 32'd1);
        chk("basic_last_latency", 32'(out_cyc[q0 + 19] - c), 32'd20);
        chk("basic_ready_after", 32'(ready), 32'h1);

        // Zero-length packet: 16 header bytes only, payload port never requested.
        h1 = mk_hdr(48'h112233445566, 32'h0A000001, 16'h0400, 16'h0800, 16'd0);
        q0 = out_q.size();
        u0 = udr_cnt;
        send_header("zero", h1);
        wait_out("zero", q0 + 16, 100);
        repeat (4) @(negedge clock);
        chk("zero_count", 32'(out_q.size() - q0), 32'd16);
        check_pkt("zero", h1, 0, 0, q0);
        chk("zero_udp_ready_cycles", 32'(udr_cnt - u0), 32'd0);

        // Backpressure: data_ready toggles every cycle.
        h1 = mk_hdr(48'h0A1B2C3D4E5F, 32'hC0A80164, 16'h1F90, 16'h0035, 16'd4);
        q0 = out_q.size();
        s0 = stall_cnt;
        sv0 = stall_viol;
        hv0 = hold_viol;
        @(posedge clock);
        #2;
        setup_payload(4, 4, 8'h11, 8'h11, pb);
        bp_mode = 1'b1;
        send_header("bp", h1);
        wait_out("bp", q0 + 20, 200);
        repeat (4) @(negedge clock);
        @(posedge clock);
        #2;
        bp_mode = 1'b0;
        repeat (2) @(negedge clock);
        chk("bp_count", 32'(out_q.size() - q0), 32'd20);
        check_pkt("bp", h1, 4, pb, q0);
        chk("bp_stalls_seen", 32'(stall_cnt - s0 > 0), 32'd1);
        chk("bp_udp_ready_in_stall", 32'(stall_viol - sv0), 32'd0);
        chk("bp_hold_violations", 32'(hold_viol - hv0), 32'd0);

        // Oversize: 1473 bytes drained, nothing emitted, one drop pulse.
        h1 = mk_hdr(48'hDEADBEEF0001, 32'h01020304, 16'h1234, 16'h5678, 16'd1473);
        q0 = out_q.size();
        d0 = drop_cnt;
        dv0 = dv_cnt;
        @(posedge clock);
        #2;
        setup_payload(1473, 1473, 3, 7, p0);
        send_header("drain", h1);
        begin
            int t = 0;
            while (drop_cnt == d0 && t < 3000) begin
                @(negedge clock);
                t++;
            end
        end
        repeat (4) @(negedge clock);
        chk("drain_beats", 32'(pay_idx - p0), 32'd1473);
        chk("drain_drop_pulses", 32'(drop_cnt - d0), 32'd1);
        chk("drain_data_valid_cycles", 32'(dv_cnt - dv0), 32'd0);
        chk("drain_no_output", 32'(out_q.size() - q0), 32'd0);
        chk("drain_ready_after", 32'(ready), 32'h1);
        chk("drain_drop_low_after", 32'(oversize_drop), 32'h0);

        // Exactly at the limit: forwarded normally.
        h1 = mk_hdr(48'h02AABBCCDDEE, 32'hAC100A0B, 16'hC350, 16'h01BB, 16'd1472);
        q0 = out_q.size();
        d0 = drop_cnt;
        @(posedge clock);
        #2;
        setup_payload(1472, 1472, 9, 13, pb);
        send_header("max", h1);
        wait_out("max", q0 + 1488, 3000);
        repeat (4) @(negedge clock);
        chk("max_count", 32'(out_q.size() - q0), 32'd1488);
        check_pkt("max", h1, 1472, pb, q0);
        chk("max_no_drop", 32'(drop_cnt - d0), 32'd0);

        // Reset in the middle of the payload: only two of four payload bytes offered.
        h1 = mk_hdr(48'h0A1B2C3D4E5F, 32'hC0A80164, 16'h1F90, 16'h0035, 16'd4);
        q0 = out_q.size();
        @(posedge clock);
        #2;
        setup_payload(4, 2, 8'h55, 8'h01, pb);
        send_header("mid", h1);
        wait_out("mid", q0 + 18, 100);
        repeat (3) @(negedge clock);
        chk("mid_stalled_count", 32'(out_q.size() - q0), 32'd18);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        pay_end = pay_idx;
        @(posedge clock);
        @(negedge clock);
        chk("mid_reset_data", 32'(data), 32'h0);
        chk("mid_reset_data_valid", 32'(data_valid), 32'h0);
        chk("mid_reset_data_last", 32'(data_last), 32'h0);
        chk("mid_reset_oversize_drop", 32'(oversize_drop), 32'h0);
        chk("mid_reset_header_ready", 32'(header_ready), 32'h1);
        chk("mid_reset_ready", 32'(ready), 32'h1);
        chk("mid_reset_udp_data_ready", 32'(udp_data_ready), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        h1 = mk_hdr(48'h665544332211, 32'h08080808, 16'h0101, 16'h0202, 16'd4);
        q0 = out_q.size();
        @(posedge clock);
        #2;
        setup_payload(4, 4, 8'hA0, 8'h05, pb);
        send_header("after_reset", h1);
        wait_out("after_reset", q0 + 20, 100);
        repeat (4) @(negedge clock);
        chk("after_reset_count", 32'(out_q.size() - q0), 32'd20);
        check_pkt("after_reset", h1, 4, pb, q0);

        // Back-to-back: header_valid held across two packets sharing one payload stream.
        h1 = mk_hdr(48'h0000000000A1, 32'h00000001, 16'h0001, 16'h0002, 16'd3);
        h2 = mk_hdr(48'h0000000000B2, 32'h00000002, 16'h0003, 16'h0004, 16'd2);
        q0 = out_q.size();
        h0 = hdr_cyc.size();
        @(posedge clock);
        #2;
        setup_payload(5, 5, 8'h30, 8'h01, pb);
        drive_fields(h1);
        header_valid = 1'b1;
        wait_hdr("b2b_first", h0 + 1, 100);
        @(posedge clock);
        #2;
        drive_fields(h2);
        wait_hdr("b2b_second", h0 + 2, 200);
        @(posedge clock);
        #2;
        header_valid = 1'b0;
        wait_out("b2b", q0 + 37, 200);
        repeat (4) @(negedge clock);
        chk("b2b_count", 32'(out_q.size() - q0), 32'd37);
        check_pkt("b2b_a", h1, 3, pb, q0);
        check_pkt("b2b_b", h2, 2, pb + 3, q0 + 19);
        chk("b2b_no_overlap", 32'(hdr_cyc[h0 + 1] > out_cyc[q0 + 18]), 32'd1);
        chk("b2b_second_sop", 32'(out_q[q0 + 19][8]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
